// File: rtl/noc_input_buffer.sv
// noc_input_buffer: per-port input FIFO of the 5-port router.
// Buffers incoming flits, checks header/body/tail framing and presents the
// head packet (req, flit_id, length) to the arbiter. One flit is popped per
// granted cycle; popped flits appear registered on out_valid/out_data.
module noc_input_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_flit_id,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_flit_id,
  output logic [AW:0]       count,
  output logic              err_drop
);

  localparam logic [2:0]    ID_HEAD  = 3'b001;
  localparam logic [2:0]    ID_BODY  = 3'b010;
  localparam logic [2:0]    ID_TAIL  = 3'b100;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  // Only the three one-hot framing codes may enter the FIFO.
  function automatic logic id_legal(input logic [2:0] id);
    return (id == ID_HEAD) || (id == ID_BODY) || (id == ID_TAIL);
  endfunction

  logic [DATA_W-1:0] mem_data_r [DEPTH];
  logic [2:0]        mem_id_r   [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  state_t            state_r;
  state_t            state_s;

  logic              empty_s;
  logic              in_ready_s;
  logic              push_s;
  logic              illegal_s;
  logic              pop_s;
  logic              drop_s;
  logic              miss_tail_s;
  logic              remove_s;
  logic              req_s;
  logic [2:0]        head_id_s;
  logic [DATA_W-1:0] head_data_s;

  assign empty_s     = (count_r == CNT_ZERO);
  // Held low during reset so upstream never pushes into a FIFO being cleared.
  assign in_ready_s  = rst && (count_r != CNT_FULL);
  assign push_s      = in_valid && in_ready_s && id_legal(in_flit_id);
  assign illegal_s   = in_valid && in_ready_s && !id_legal(in_flit_id);
  assign head_id_s   = mem_id_r[rd_ptr_r];
  assign head_data_s = mem_data_r[rd_ptr_r];
  // Orphan discards free the entry exactly like a pop, just without out_valid.
  assign remove_s    = pop_s || drop_s;

  assign in_ready = in_ready_s;
  assign req      = req_s;
  assign flit_id  = empty_s ? 3'b000 : head_id_s;
  assign count    = count_r;
  assign err_drop = illegal_s || drop_s || miss_tail_s;

  // Framing FSM next state, pop/discard decisions and arbiter request.
  always_comb begin
    state_s     = state_r;
    pop_s       = 1'b0;
    drop_s      = 1'b0;
    miss_tail_s = 1'b0;
    req_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (empty_s) begin
          req_s = 1'b0;
        end else if (head_id_s == ID_HEAD) begin
          req_s = 1'b1;
          if (grant) begin
            pop_s   = 1'b1;
            state_s = ST_PKT;
          end else begin
            pop_s = 1'b0;
          end
        end else begin
          // Body/tail with no open packet: discard one per cycle.
          drop_s = 1'b1;
        end
      end
      ST_PKT: begin
        req_s = !empty_s;
        if (empty_s) begin
          pop_s = 1'b0;
        end else if (head_id_s == ID_HEAD) begin
          // Missing tail: keep the new header and re-serve it from IDLE.
          miss_tail_s = 1'b1;
          state_s     = ST_IDLE;
        end else if (grant) begin
          pop_s = 1'b1;
          if (head_id_s == ID_TAIL) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_PKT;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage; every entry is written before it can be read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_r[wr_ptr_r] <= in_data;
      mem_id_r[wr_ptr_r]   <= in_flit_id;
    end
  end

  // Pointers, occupancy and FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
      state_r  <= ST_IDLE;
    end else begin
      state_r <= state_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (remove_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, remove_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Packet length latched whenever a header waits at the head in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      length <= 12'h000;
    end else if ((state_r == ST_IDLE) && !empty_s && (head_id_s == ID_HEAD)) begin
      length <= head_data_s[11:0];
    end
  end

  // Registered crossbar output, one cycle after each pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_flit_id <= 3'b000;
    end else begin
      out_valid <= pop_s;
      if (pop_s) begin
        out_data    <= head_data_s;
        out_flit_id <= head_id_s;
      end
    end
  end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed testbench for noc_input_buffer (DATA_W=32, DEPTH=8).
module tb_noc_input_buffer;

  localparam logic [2:0] H = 3'b001;
  localparam logic [2:0] B = 3'b010;
  localparam logic [2:0] T = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic [2:0]  in_flit_id = 3'b000;
  logic        grant = 1'b0;
  logic        req;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_flit_id;
  logic [3:0]  count;
  logic        err_drop;

  int n_cmp = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int cyc_cnt = 0;
  logic [34:0] q_flit[$];
  int          q_cyc[$];

  noc_input_buffer #(.DATA_W(32), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_flit_id(in_flit_id), .grant(grant), .req(req),
    .flit_id(flit_id), .length(length), .out_valid(out_valid),
    .out_data(out_data), .out_flit_id(out_flit_id), .count(count),
    .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Record every delivered flit with the cycle it appeared in.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      q_flit.push_back({out_flit_id, out_data});
      q_cyc.push_back(cyc_cnt);
    end
  end

  // Count err_drop pulses, sampled mid-cycle after inputs settle.
  always @(negedge clk) begin
    #3;
    if (rst && err_drop) err_cnt++;
  end

  task automatic drv(input logic v, input logic [2:0] id, input logic [31:0] d, input logic g);
    in_valid = v; in_flit_id = id; in_data = d; grant = g;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    drv(1'b0, 3'b000, 32'h0, 1'b0);
    cyc(2);
    rst = 1'b1;
    drv(1'b1, H, 32'h1234_0003, 1'b1); cyc(1);
    drv(1'b1, B, 32'h1234_0B01, 1'b1); cyc(1);
    drv(1'b1, B, 32'h1234_0B02, 1'b1); cyc(1);
    rst = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", req); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (err_drop !== 1'b0) begin n_fail++; $display("FAIL rst_err_drop: got %b want 0", err_drop); end
    n_cmp++; if (length !== 12'h000) begin n_fail++; $display("FAIL rst_length: got %h want 000", length); end
    drv(1'b0, 3'b000, 32'h0, 1'b0);
    cyc(2);
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (flit_id !== 3'b000) begin n_fail++; $display("FAIL rel_flit_id: got %b want 000", flit_id); end
    cyc(1);
  endtask

  task automatic test_basic_packet();
    logic [34:0] exp_f[4];
    int qs = q_flit.size();
    int e0 = err_cnt;
    exp_f = '{{H, 32'h1111_000A}, {B, 32'h2222_2222}, {B, 32'h3333_3333}, {T, 32'h4444_4444}};
    drv(1'b1, H, 32'h1111_000A, 1'b1); cyc(1);
    drv(1'b1, B, 32'h2222_2222, 1'b1);
    #1;
    n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %b want 1", req); end
    n_cmp++; if (flit_id !== H) begin n_fail++; $display("FAIL basic_head_id: got %b want %b", flit_id, H); end
    cyc(1);
    drv(1'b1, B, 32'h3333_3333, 1'b1);
    #1;
    n_cmp++; if (length !== 12'h00A) begin n_fail++; $display("FAIL basic_length: got %h want 00a", length); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hdr_latency: got %b want 1", out_valid); end
    cyc(1);
    drv(1'b1, T, 32'h4444_4444, 1'b1); cyc(1);
    drv(1'b0, 3'b000, 32'h0, 1'b1); cyc(4);
    n_cmp++;
    if (q_flit.size() - qs !== 4) begin
      n_fail++; $display("FAIL basic_nflits: got %0d want 4", q_flit.size() - qs);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (q_flit[qs+i] !== exp_f[i]) begin
          n_fail++; $display("FAIL basic_flit%0d: got %h want %h", i, q_flit[qs+i], exp_f[i]);
        end
        if (i > 0 && q_cyc[qs+i] !== q_cyc[qs+i-1] + 1) begin
          n_fail++; $display("FAIL basic_gap%0d: got cycle %0d want %0d", i, q_cyc[qs+i], q_cyc[qs+i-1] + 1);
        end
      end
    end
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL basic_count: got %0d want 0", count); end
    n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL basic_req_end: got %b want 0", req); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL basic_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_full();
    logic [2:0]  ids[9];
    logic [31:0] dat[9];
    logic [34:0] exp_f[10];
    int qs = q_flit.size();
    int e0 = err_cnt;
    ids = '{H, B, B, B, B, B, B, T, H};
    dat = '{32'hC000_0008, 32'hC000_0011, 32'hC000_0012, 32'hC000_0013, 32'hC000_0014,
            32'hC000_0015, 32'hC000_0016, 32'hC000_0020, 32'hC000_0002};
    exp_f = '{{H, 32'hC000_0008}, {B, 32'hC000_0011}, {B, 32'hC000_0012}, {B, 32'hC000_0013},
              {B, 32'hC000_0014}, {B, 32'hC000_0015}, {B, 32'hC000_0016}, {T, 32'hC000_0020},
              {H, 32'hC000_0002}, {T, 32'hC000_0030}};
    for (int i = 0; i < 9; i++) begin
      drv(1'b1, ids[i], dat[i], 1'b0);
      #1;
      if (i == 8) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      end
      cyc(1);
    end
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", count); end
    drv(1'b1, H, 32'hC000_0002, 1'b1); cyc(1);
    n_cmp++; if (count !== 4'd7) begin n_fail++; $display("FAIL full_cnt_a: got %0d want 7", count); end
    drv(1'b1, H, 32'hC000_0002, 1'b0); cyc(1);
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_cnt_b: got %0d want 8", count); end
    drv(1'b1, T, 32'hC000_0030, 1'b1);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_pop: got %b want 0", in_ready); end
    cyc(1);
    n_cmp++; if (count !== 4'd7) begin n_fail++; $display("FAIL full_cnt_c: got %0d want 7", count); end
    drv(1'b1, T, 32'hC000_0030, 1'b0); cyc(1);
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_cnt_d: got %0d want 8", count); end
    drv(1'b0, 3'b000, 32'h0, 1'b1); cyc(14);
    n_cmp++;
    if (q_flit.size() - qs !== 10) begin
      n_fail++; $display("FAIL full_nflits: got %0d want 10", q_flit.size() - qs);
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (q_flit[qs+i] !== exp_f[i]) begin
          n_fail++; $display("FAIL full_flit%0d: got %h want %h", i, q_flit[qs+i], exp_f[i]);
        end
      end
    end
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL full_drain: got %0d want 0", count); end
    n_cmp++; if (length !== 12'h002) begin n_fail++; $display("FAIL full_length: got %h want 002", length); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL full_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_orphan();
    int qs = q_flit.size();
    int e0 = err_cnt;
    drv(1'b1, B, 32'hDEAD_0001, 1'b1); cyc(1);
    drv(1'b1, T, 32'hDEAD_0002, 1'b1);
    #1;
    n_cmp++; if (err_drop !== 1'b1) begin n_fail++; $display("FAIL orphan_pulse: got %b want 1", err_drop); end
    n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL orphan_req: got %b want 0", req); end
    cyc(1);
    drv(1'b1, H, 32'h5000_0005, 1'b1); cyc(1);
    drv(1'b1, T, 32'h6000_0006, 1'b1); cyc(1);
    drv(1'b0, 3'b000, 32'h0, 1'b1); cyc(4);
    n_cmp++;
    if (q_flit.size() - qs !== 2) begin
      n_fail++; $display("FAIL orphan_nflits: got %0d want 2", q_flit.size() - qs);
    end else begin
      if (q_flit[qs] !== {H, 32'h5000_0005}) begin n_fail++; $display("FAIL orphan_h: got %h want %h", q_flit[qs], {H, 32'h5000_0005}); end
      if (q_flit[qs+1] !== {T, 32'h6000_0006}) begin n_fail++; $display("FAIL orphan_t: got %h want %h", q_flit[qs+1], {T, 32'h6000_0006}); end
    end
    n_cmp++; if (err_cnt - e0 !== 2) begin n_fail++; $display("FAIL orphan_err: got %0d want 2", err_cnt - e0); end
    n_cmp++; if (length !== 12'h005) begin n_fail++; $display("FAIL orphan_length: got %h want 005", length); end
    drv(1'b1, 3'b011, 32'hBAD0_0000, 1'b1);
    #1;
    n_cmp++; if (err_drop !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: got %b want 1", err_drop); end
    cyc(1);
    drv(1'b0, 3'b000, 32'h0, 1'b1);
    #1;
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL illegal_count: got %0d want 0", count); end
    cyc(2);
    n_cmp++; if (q_flit.size() - qs !== 2) begin n_fail++; $display("FAIL illegal_out: got %0d want 2", q_flit.size() - qs); end
  endtask

  task automatic test_missing_tail();
    logic [34:0] exp_f[4];
    int qs = q_flit.size();
    int e0 = err_cnt;
    exp_f = '{{H, 32'h7000_0007}, {B, 32'h7000_0B0B}, {H, 32'h8000_0003}, {T, 32'h8000_0E0E}};
    drv(1'b1, H, 32'h7000_0007, 1'b1); cyc(1);
    drv(1'b1, B, 32'h7000_0B0B, 1'b1); cyc(1);
    drv(1'b1, H, 32'h8000_0003, 1'b1); cyc(1);
    drv(1'b1, T, 32'h8000_0E0E, 1'b1);
    #1;
    n_cmp++; if (err_drop !== 1'b1) begin n_fail++; $display("FAIL mtail_pulse: got %b want 1", err_drop); end
    n_cmp++; if (length !== 12'h007) begin n_fail++; $display("FAIL mtail_len_hold: got %h want 007", length); end
    cyc(1);
    drv(1'b0, 3'b000, 32'h0, 1'b1);
    #1;
    n_cmp++; if (err_drop !== 1'b0) begin n_fail++; $display("FAIL mtail_pulse_end: got %b want 0", err_drop); end
    cyc(4);
    n_cmp++;
    if (q_flit.size() - qs !== 4) begin
      n_fail++; $display("FAIL mtail_nflits: got %0d want 4", q_flit.size() - qs);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (q_flit[qs+i] !== exp_f[i]) begin
          n_fail++; $display("FAIL mtail_flit%0d: got %h want %h", i, q_flit[qs+i], exp_f[i]);
        end
      end
    end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL mtail_err: got %0d want 1", err_cnt - e0); end
    n_cmp++; if (length !== 12'h003) begin n_fail++; $display("FAIL mtail_length: got %h want 003", length); end
  endtask

  task automatic test_grant_loss();
    int qs = q_flit.size();
    int e0 = err_cnt;
    drv(1'b1, H, 32'hA000_0004, 1'b1); cyc(1);
    drv(1'b1, B, 32'hA000_0B00, 1'b1); cyc(1);
    drv(1'b1, T, 32'hA000_0E00, 1'b0); cyc(1);
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 3'b000, 32'h0, 1'b0);
      #1;
      n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL gloss_req%0d: got %b want 1", i, req); end
      n_cmp++; if (count !== 4'd2) begin n_fail++; $display("FAIL gloss_count%0d: got %0d want 2", i, count); end
      n_cmp++; if (flit_id !== B) begin n_fail++; $display("FAIL gloss_head%0d: got %b want %b", i, flit_id, B); end
      cyc(1);
    end
    n_cmp++; if (q_flit.size() - qs !== 1) begin n_fail++; $display("FAIL gloss_nopop: got %0d want 1", q_flit.size() - qs); end
    drv(1'b0, 3'b000, 32'h0, 1'b1); cyc(4);
    n_cmp++;
    if (q_flit.size() - qs !== 3) begin
      n_fail++; $display("FAIL gloss_nflits: got %0d want 3", q_flit.size() - qs);
    end else begin
      if (q_flit[qs+1] !== {B, 32'hA000_0B00}) begin n_fail++; $display("FAIL gloss_b: got %h want %h", q_flit[qs+1], {B, 32'hA000_0B00}); end
      if (q_flit[qs+2] !== {T, 32'hA000_0E00}) begin n_fail++; $display("FAIL gloss_t: got %h want %h", q_flit[qs+2], {T, 32'hA000_0E00}); end
      if (q_cyc[qs+2] !== q_cyc[qs+1] + 1) begin n_fail++; $display("FAIL gloss_gap: got cycle %0d want %0d", q_cyc[qs+2], q_cyc[qs+1] + 1); end
    end
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL gloss_drain: got %0d want 0", count); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL gloss_err: got %0d want 0", err_cnt - e0); end
    drv(1'b0, 3'b000, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_full();
    test_orphan();
    test_missing_tail();
    test_grant_loss();
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
